// File: rtl/led_pkg.sv
// Shared types and helpers for the LED fade sequencer and the PWM generator it drives.
package led_pkg;

   localparam int DUTY_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef enum logic {
      MODE_RAMP  = 1'b0,
      MODE_BLINK = 1'b1
   } mode_t;

   function automatic int period_clks(input int clk_freq, input int out_freq);
      return clk_freq / out_freq;
   endfunction

endpackage

// File: rtl/led_fade_ctrl_period_timer.sv
// Free-running PWM period counter; strobes on the last clock of every period.
module period_timer
   import led_pkg::*;
#(
   parameter int CLK_FREQ = 20480000,
   parameter int OUT_FREQ = 100000
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_ptick
);

   localparam int PERIOD = period_clks(CLK_FREQ, OUT_FREQ);
   localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CNT_W-1:0] r_pcnt;
   logic             w_last;

   assign w_last  = (r_pcnt == CNT_W'(PERIOD - 1));
   assign o_ptick = w_last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pcnt <= '0;
      end else if (w_last) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_fade_ctrl.sv
// Command-driven duty sequencer: ramps or blinks the PWM duty, updating only on period boundaries.
module led_fade_ctrl
   import led_pkg::*;
#(
   parameter int CLK_FREQ = 20480000,
   parameter int OUT_FREQ = 100000
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_mode,
   input  logic [DUTY_W-1:0] cmd_target,
   input  logic [7:0]        cmd_rate,
   input  logic [7:0]        cmd_hold,
   output logic [DUTY_W-1:0] duty,
   output logic              LEDen,
   output logic              busy,
   output logic              ptick
);

   state_t            r_state;
   mode_t             r_mode;
   logic [DUTY_W-1:0] r_target;
   logic [7:0]        r_rate;
   logic [7:0]        r_hold;
   logic [7:0]        r_scnt;
   logic [7:0]        r_hcnt;
   logic              r_phase_up;
   logic [DUTY_W-1:0] r_duty;
   logic              r_leden;

   logic              w_ptick;
   logic              w_accept;
   logic [DUTY_W-1:0] w_goal;
   logic              w_step_now;
   logic [DUTY_W-1:0] w_duty_next;
   logic              w_ramp_done;
   logic [7:0]        w_hold_last;

   period_timer #(
      .CLK_FREQ (CLK_FREQ),
      .OUT_FREQ (OUT_FREQ)
   ) u_timer (
      .i_clk   (clk),
      .i_rst   (Reset),
      .o_ptick (w_ptick)
   );

   assign ptick     = w_ptick;
   assign duty      = r_duty;
   assign LEDen     = r_leden;
   assign busy      = (r_state != IDLE);
   assign cmd_ready = (r_state == IDLE) || (r_mode == MODE_BLINK);
   assign w_accept  = cmd_valid && cmd_ready;

   assign w_goal      = r_phase_up ? r_target : '0;
   assign w_step_now  = (r_rate == 8'd0) || (r_scnt == r_rate - 8'd1);
   assign w_hold_last = (r_hold == 8'd0) ? 8'd0 : r_hold - 8'd1;

   // Stepping only moves toward the goal, so duty can never wrap past 0 or 255.
   always_comb begin
      w_duty_next = r_duty;
      if (r_rate == 8'd0) begin
         w_duty_next = w_goal;
      end else if (w_step_now) begin
         if (r_duty < w_goal) begin
            w_duty_next = r_duty + 8'd1;
         end else if (r_duty > w_goal) begin
            w_duty_next = r_duty - 8'd1;
         end
      end
   end

   assign w_ramp_done = (w_duty_next == w_goal);

   // A freshly accepted command wins over a coinciding ptick, so the old sequence skips that update.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_mode     <= MODE_RAMP;
         r_target   <= '0;
         r_rate     <= '0;
         r_hold     <= '0;
         r_scnt     <= '0;
         r_hcnt     <= '0;
         r_phase_up <= 1'b1;
         r_duty     <= '0;
         r_leden    <= 1'b0;
      end else if (w_accept) begin
         r_state    <= RAMP;
         r_mode     <= mode_t'(cmd_mode);
         r_target   <= cmd_target;
         r_rate     <= cmd_rate;
         r_hold     <= cmd_hold;
         r_scnt     <= '0;
         r_hcnt     <= '0;
         r_phase_up <= 1'b1;
      end else if (w_ptick) begin
         case (r_state)
            RAMP: begin
               r_duty  <= w_duty_next;
               r_leden <= (w_duty_next != '0);
               if (w_ramp_done) begin
                  r_state <= (r_mode == MODE_BLINK) ? HOLD : IDLE;
                  r_hcnt  <= '0;
                  r_scnt  <= '0;
               end else if (r_rate != 8'd0) begin
                  r_scnt <= w_step_now ? 8'd0 : r_scnt + 8'd1;
               end
            end
            HOLD: begin
               r_hcnt <= r_hcnt + 8'd1;
               if (r_hcnt == w_hold_last) begin
                  r_phase_up <= ~r_phase_up;
                  r_scnt     <= '0;
                  r_state    <= RAMP;
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Bench for led_fade_ctrl: a per-period duty schedule model checked every cycle, plus directed literal checks.
module tb_led_fade_ctrl;

   localparam int P = 20480000 / 100000;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_mode = 1'b0;
   logic [7:0] cmd_target = 8'd0;
   logic [7:0] cmd_rate = 8'd0;
   logic [7:0] cmd_hold = 8'd0;
   logic       cmd_ready;
   logic [7:0] duty;
   logic       LEDen;
   logic       busy;
   logic       ptick;

   int checks = 0;
   int failures = 0;

   led_fade_ctrl #(
      .CLK_FREQ (20480000),
      .OUT_FREQ (100000)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_target (cmd_target),
      .cmd_rate   (cmd_rate),
      .cmd_hold   (cmd_hold),
      .duty       (duty),
      .LEDen      (LEDen),
      .busy       (busy),
      .ptick      (ptick)
   );

   initial forever #5 clk = ~clk;

   // Model: each accepted command becomes a queue of duty values, one per period boundary.
   int m_pcnt = 0;
   int m_duty = 0;
   int m_tgt = 0;
   int m_rate = 0;
   int m_hold = 1;
   bit m_active = 1'b0;
   bit m_blink = 1'b0;
   bit m_next_up = 1'b0;
   int q[$];

   function automatic void push_ramp(input int from, input int to, input int rate);
      int n;
      n = (to > from) ? to - from : from - to;
      if (n == 0 || rate == 0) begin
         q.push_back(to);
      end else begin
         for (int k = 1; k <= n * rate; k++) begin
            q.push_back((to > from) ? from + k / rate : from - k / rate);
         end
      end
   endfunction

   function automatic void push_segment(input int from, input int goal);
      push_ramp(from, goal, m_rate);
      for (int k = 0; k < m_hold; k++) q.push_back(goal);
   endfunction

   initial begin
      bit tk;
      bit rdy;
      forever begin
         @(posedge clk or posedge Reset);
         if (Reset) begin
            m_pcnt = 0;
            m_duty = 0;
            m_active = 1'b0;
            m_blink = 1'b0;
            q.delete();
         end else begin
            tk  = (m_pcnt == P - 1);
            rdy = !m_active || m_blink;
            m_pcnt = tk ? 0 : m_pcnt + 1;
            if (cmd_valid && rdy) begin
               m_tgt    = int'(cmd_target);
               m_rate   = int'(cmd_rate);
               m_hold   = (cmd_hold == 8'd0) ? 1 : int'(cmd_hold);
               m_blink  = cmd_mode;
               m_active = 1'b1;
               q.delete();
               if (m_blink) begin
                  push_segment(m_duty, m_tgt);
                  m_next_up = 1'b0;
               end else begin
                  push_ramp(m_duty, m_tgt, m_rate);
               end
            end else if (tk && m_active) begin
               m_duty = q.pop_front();
               if (q.size() == 0) begin
                  if (m_blink) begin
                     push_segment(m_duty, m_next_up ? m_tgt : 0);
                     m_next_up = !m_next_up;
                  end else begin
                     m_active = 1'b0;
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [11:0] act;
      logic [11:0] exp;
      logic [7:0]  md;
      forever begin
         @(negedge clk);
         md  = m_duty[7:0];
         act = {duty, LEDen, busy, cmd_ready, ptick};
         exp = {md, (m_duty != 0), m_active, (!m_active || m_blink), (m_pcnt == P - 1)};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL cycle_compare t=%0t dut duty=%0d LEDen=%0b busy=%0b ready=%0b ptick=%0b required duty=%0d LEDen=%0b busy=%0b ready=%0b ptick=%0b",
                     $time, act[11:4], act[3], act[2], act[1], act[0], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ptick_cycle();
      int n = 0;
      while (m_pcnt != P - 1 && n < P + 4) begin
         tick();
         n++;
      end
      if (m_pcnt != P - 1) begin
         checks++;
         failures++;
         $display("FAIL ptick_timeout got=%0d required=%0d", m_pcnt, P - 1);
      end
   endtask

   task automatic after_ptick();
      wait_ptick_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit mode, input int tgt, input int rate, input int hold);
      cmd_mode   = mode;
      cmd_target = 8'(tgt);
      cmd_rate   = 8'(rate);
      cmd_hold   = 8'(hold);
      cmd_valid  = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
   endtask

   initial begin
      int pat[12];
      pat = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0};

      repeat (3) @(posedge clk);
      #2;
      chk("reset_duty", duty, 0);
      chk("reset_leden", LEDen, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ptick", ptick, 0);
      chk("reset_ready", cmd_ready, 1);
      Reset = 1'b0;
      tick();

      send(1'b0, 200, 0, 0);
      chk("jump_busy_rise", busy, 1);
      after_ptick();
      chk("jump_duty", duty, 200);
      chk("jump_leden", LEDen, 1);
      chk("jump_busy_fall", busy, 0);

      send(1'b0, 5, 0, 0);
      after_ptick();
      chk("to5_duty", duty, 5);

      send(1'b0, 0, 1, 0);
      for (int k = 1; k <= 5; k++) begin
         after_ptick();
         chk("down_duty", duty, 5 - k);
         chk("down_leden", LEDen, (k < 5) ? 1 : 0);
         chk("down_busy", busy, (k < 5) ? 1 : 0);
      end

      send(1'b0, 10, 3, 0);
      for (int k = 1; k <= 30; k++) begin
         chk("slow_ready", cmd_ready, 0);
         after_ptick();
         chk("slow_duty", duty, k / 3);
      end
      chk("slow_busy_end", busy, 0);

      send(1'b0, 0, 0, 0);
      after_ptick();
      chk("clear_duty", duty, 0);

      send(1'b1, 4, 1, 2);
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 12; i++) begin
            after_ptick();
            chk("blink_duty", duty, pat[i]);
            chk("blink_ready", cmd_ready, 1);
         end
      end

      for (int k = 1; k <= 3; k++) begin
         after_ptick();
         chk("pre_blink_duty", duty, k);
      end
      wait_ptick_cycle();
      send(1'b0, 8, 1, 0);
      chk("preempt_no_update", duty, 3);
      chk("preempt_ready", cmd_ready, 0);
      for (int k = 1; k <= 5; k++) begin
         after_ptick();
         chk("preempt_duty", duty, 3 + k);
      end
      chk("preempt_busy_end", busy, 0);

      send(1'b1, 0, 2, 0);
      for (int k = 1; k <= 16; k++) begin
         after_ptick();
         chk("blink0_duty", duty, 8 - k / 2);
      end
      for (int k = 0; k < 4; k++) begin
         after_ptick();
         chk("blink0_hold_duty", duty, 0);
         chk("blink0_busy", busy, 1);
      end

      send(1'b0, 50, 1, 0);
      for (int k = 1; k <= 3; k++) after_ptick();
      chk("mid_duty", duty, 3);
      #1;
      Reset = 1'b1;
      #1;
      chk("rst_mid_duty", duty, 0);
      chk("rst_mid_leden", LEDen, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", cmd_ready, 1);
      tick();
      tick();
      Reset = 1'b0;
      repeat (P + 10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
